// File: rtl/order_entry_arbiter.sv
// Round-robin arbiter for the shared order-entry TX path with token-bucket rate limiting
// and session sequence stamping. Optional kill switch enabled by defining OE_KILL_SWITCH_EN.
module order_entry_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ORDER_W    = 64,
    parameter int SEQ_W      = 32,
    parameter int BUCKET_MAX = 8,
    parameter int REFILL_DIV = 125,
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TOK_W = $clog2(BUCKET_MAX + 1),
    localparam int REF_W = (REFILL_DIV > 1) ? $clog2(REFILL_DIV) : 1
) (
    input  logic                       clk_125mhz,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ORDER_W-1:0] req_order,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       ord_valid,
    output logic [ORDER_W-1:0]         ord_data,
    output logic [SRC_W-1:0]           ord_src,
    output logic [SEQ_W-1:0]           ord_seq,
    input  logic                       ord_ready,
    output logic [TOK_W-1:0]           tokens_avail,
`ifdef OE_KILL_SWITCH_EN
    input  logic                       kill_sw,
    output logic [15:0]                drop_cnt,
`endif
    output logic                       busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] rr_ptr;
    logic [TOK_W-1:0] tokens;
    logic [SEQ_W-1:0] seq_cnt;
    logic [REF_W-1:0] refill_cnt;
    logic [SRC_W-1:0] probe;
    logic [SRC_W-1:0] pick;
    logic             any_hit;
    logic             refill_tick;
    logic             tokens_ok;
    logic             grant;
    logic             take;

    assign refill_tick  = (refill_cnt == REF_W'(REFILL_DIV - 1));
    // A refill landing on an empty bucket makes a grant legal in the same cycle.
    assign tokens_ok    = (tokens != '0) || refill_tick;
    assign tokens_avail = tokens;
    assign ord_valid    = (state == SEND);
    assign busy         = (state == SEND);

    always_comb begin
        probe   = '0;
        pick    = '0;
        any_hit = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            probe = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_hit && req_valid[probe]) begin
                pick    = probe;
                any_hit = 1'b1;
            end
        end
    end

`ifdef OE_KILL_SWITCH_EN
    logic drop;
    assign grant = !rst && !kill_sw && (state == IDLE) && any_hit && tokens_ok;
    assign drop  = !rst && kill_sw && any_hit;
    assign take  = grant || drop;
`else
    assign grant = !rst && (state == IDLE) && any_hit && tokens_ok;
    assign take  = grant;
`endif

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[pick] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = SEND;
            SEND:    if (ord_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            state      <= IDLE;
            tokens     <= TOK_W'(BUCKET_MAX);
            rr_ptr     <= SRC_W'(NUM_REQ - 1);
            seq_cnt    <= '0;
            refill_cnt <= '0;
            ord_data   <= '0;
            ord_src    <= '0;
            ord_seq    <= '0;
        end else begin
            state      <= state_nxt;
            refill_cnt <= refill_tick ? '0 : refill_cnt + 1'b1;
            if (take) begin
                rr_ptr <= pick;
            end
            if (grant) begin
                ord_data <= req_order[pick*ORDER_W +: ORDER_W];
                ord_src  <= pick;
                ord_seq  <= seq_cnt;
                seq_cnt  <= seq_cnt + 1'b1;
            end
            // Consume and refill in the same cycle cancel out.
            if (grant && !refill_tick) begin
                tokens <= tokens - 1'b1;
            end else if (!grant && refill_tick && tokens != TOK_W'(BUCKET_MAX)) begin
                tokens <= tokens + 1'b1;
            end
        end
    end

`ifdef OE_KILL_SWITCH_EN
    always_ff @(posedge clk_125mhz) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_order_entry_arbiter.sv
// Scoreboard bench for order_entry_arbiter: cycle-level reference model predicts grants,
// a separate monitor checks every presented order against the expected queue.
`timescale 1ns/1ps
module tb_order_entry_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ORDER_W    = 64;
    localparam int SEQ_W      = 4;
    localparam int BUCKET_MAX = 8;
    localparam int REFILL_DIV = 125;

    logic                       clk_125mhz = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ORDER_W-1:0] req_order;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       ord_valid;
    logic [ORDER_W-1:0]         ord_data;
    logic [1:0]                 ord_src;
    logic [SEQ_W-1:0]           ord_seq;
    logic                       ord_ready;
    logic [3:0]                 tokens_avail;
    logic                       busy;
`ifdef OE_KILL_SWITCH_EN
    logic                       kill_sw;
    logic [15:0]                drop_cnt;
`endif

    typedef struct {
        logic [ORDER_W-1:0] data;
        int                 src;
        int                 seq;
    } order_t;

    int                 checks   = 0;
    int                 failures = 0;
    order_t             exp_q[$];
    logic [ORDER_W-1:0] pay[NUM_REQ];
    logic [NUM_REQ-1:0] refresh;
    int                 grant_log[$];
    int                 src_log[$];
    int                 cyc;

    // Reference model state: plain counters following the arbiter's rules.
    bit m_known = 1'b0;
    bit m_send;
    int m_tokens, m_refill, m_last, m_seq, m_drop;

    always #4 clk_125mhz = ~clk_125mhz;

    order_entry_arbiter #(
        .NUM_REQ(NUM_REQ), .ORDER_W(ORDER_W), .SEQ_W(SEQ_W),
        .BUCKET_MAX(BUCKET_MAX), .REFILL_DIV(REFILL_DIV)
    ) dut (
        .clk_125mhz(clk_125mhz),
        .rst(rst),
        .req_valid(req_valid),
        .req_order(req_order),
        .req_ready(req_ready),
        .ord_valid(ord_valid),
        .ord_data(ord_data),
        .ord_src(ord_src),
        .ord_seq(ord_seq),
        .ord_ready(ord_ready),
        .tokens_avail(tokens_avail),
`ifdef OE_KILL_SWITCH_EN
        .kill_sw(kill_sw),
        .drop_cnt(drop_cnt),
`endif
        .busy(busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelCycle();
        logic [NUM_REQ-1:0] exp_ready;
        bit refill, grant, drop, kill_now;
        int g;
        exp_ready = '0;
        refill    = (m_refill == REFILL_DIV - 1);
        grant     = 1'b0;
        drop      = 1'b0;
        kill_now  = 1'b0;
        g         = -1;
`ifdef OE_KILL_SWITCH_EN
        kill_now = kill_sw;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (g < 0 && ((req_valid >> ((m_last + k) % NUM_REQ)) & 1) != 0) begin
                g = (m_last + k) % NUM_REQ;
            end
        end
        if (!rst && g >= 0) begin
            if (kill_now) drop = 1'b1;
            else grant = !m_send && (m_tokens > 0 || refill);
        end
        if (grant || drop) exp_ready = NUM_REQ'(1) << g;
        checkOutput("req_ready", req_ready, exp_ready);
        if (m_known) begin
            checkOutput("tokens_avail", tokens_avail, m_tokens);
            checkOutput("ord_valid", ord_valid, m_send);
            checkOutput("busy", busy, m_send);
`ifdef OE_KILL_SWITCH_EN
            checkOutput("drop_cnt", drop_cnt, m_drop);
`endif
        end
        if (rst) begin
            m_known  = 1'b1;
            m_tokens = BUCKET_MAX;
            m_refill = 0;
            m_last   = NUM_REQ - 1;
            m_seq    = 0;
            m_send   = 1'b0;
            m_drop   = 0;
            cyc      = 0;
            exp_q.delete();
            grant_log.delete();
            src_log.delete();
        end else begin
            if (grant) begin
                exp_q.push_back('{data: pay[g], src: g, seq: m_seq});
                m_seq  = (m_seq + 1) % (1 << SEQ_W);
                m_send = 1'b1;
                m_last = g;
            end else if (m_send && ord_ready) begin
                m_send = 1'b0;
            end
            if (drop) begin
                m_last = g;
                if (m_drop < 65535) m_drop++;
            end
            if (grant && !refill) m_tokens--;
            else if (!grant && refill && m_tokens < BUCKET_MAX) m_tokens++;
            m_refill = (m_refill + 1) % REFILL_DIV;
            cyc++;
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [NUM_REQ-1:0] v, input bit ordy);
        @(negedge clk_125mhz);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (refresh[i]) pay[i] = {$urandom, $urandom};
            req_order[i*ORDER_W +: ORDER_W] = pay[i];
        end
        rst       = r;
        req_valid = v;
        ord_ready = ordy;
        #1;
        if (!rst && req_ready != '0) begin
            grant_log.push_back(cyc);
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) src_log.push_back(i);
        end
        refresh = req_ready;
        modelCycle();
    endtask

    // Monitor: every presented order must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk_125mhz);
            #2;
            if (m_known && !rst && ord_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL ord_unexpected: got src=%0d seq=%0d want no order", ord_src, ord_seq);
                end else begin
                    checkOutput("ord_data", ord_data, exp_q[0].data);
                    checkOutput("ord_src", ord_src, exp_q[0].src);
                    checkOutput("ord_seq", ord_seq, exp_q[0].seq);
                    if (ord_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        ord_ready = 1'b0;
        req_order = '0;
        refresh   = '0;
`ifdef OE_KILL_SWITCH_EN
        kill_sw = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) pay[i] = {$urandom, $urandom};

        repeat (3) applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("rst_ord_data", ord_data, 64'd0);
        checkOutput("rst_ord_src", ord_src, 64'd0);
        checkOutput("rst_ord_seq", ord_seq, 64'd0);
        checkOutput("rst_tokens", tokens_avail, 64'd8);

        $display("[TB] single requester burst and refill");
        repeat (1130) applyStimulus(1'b0, 4'b0001, 1'b1);
        checkOutput("burst_grant_count", grant_log.size(), 64'd17);
        for (int k = 0; k < 17 && k < grant_log.size(); k++) begin
            checkOutput($sformatf("burst_grant_cycle_%0d", k), grant_log[k],
                        (k < 8) ? 1 + 2 * k : 124 + 125 * (k - 8));
        end

        $display("[TB] all requesters round robin");
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1);
        repeat (20) applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rr_grant_count", src_log.size(), 64'd8);
        for (int k = 0; k < 8 && k < src_log.size(); k++) begin
            checkOutput($sformatf("rr_src_%0d", k), src_log[k], k % NUM_REQ);
        end

        $display("[TB] backpressure hold");
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        repeat (10) begin
            applyStimulus(1'b0, 4'b1111, 1'b0);
            checkOutput("hold_busy", busy, 64'd1);
            checkOutput("hold_no_ready", req_ready, 64'd0);
        end
        repeat (4) applyStimulus(1'b0, 4'b1111, 1'b1);

        $display("[TB] reset during SEND");
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'b1111, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("after_rst_valid", ord_valid, 64'd0);
        checkOutput("after_rst_tokens", tokens_avail, 64'd8);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("after_rst_src", ord_src, 64'd0);
        checkOutput("after_rst_seq", ord_seq, 64'd0);

        $display("[TB] randomized traffic");
        repeat (2500) begin
            applyStimulus($urandom_range(0, 399) == 0, NUM_REQ'($urandom), $urandom_range(0, 9) < 7);
        end

`ifdef OE_KILL_SWITCH_EN
        $display("[TB] kill switch");
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b1);
        kill_sw = 1'b1;
        repeat (6) applyStimulus(1'b0, 4'b0110, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("kill_pulses", src_log.size(), 64'd6);
        for (int k = 0; k < 6 && k < src_log.size(); k++) begin
            checkOutput($sformatf("kill_src_%0d", k), src_log[k], (k % 2 == 0) ? 1 : 2);
        end
        checkOutput("kill_drop_cnt", drop_cnt, 64'd6);
        checkOutput("kill_tokens", tokens_avail, 64'd8);
        kill_sw = 1'b0;
`endif

        repeat (4) applyStimulus(1'b0, 4'b0000, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
